// File: rtl/h_row_scheduler_if.sv
// h_row_scheduler bus bundle: control, memory read ports and row packet.
// master = scheduler side, slave = memories / consumer / controller side.
interface h_row_scheduler_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_OF_COLS     = 5,
  parameter int NUM_OF_ROWS     = 5,
  parameter int COL_INDEX_SIZE  = 8,
  parameter int COL_IDX_WIDTH   = $clog2(NUM_OF_COLS),
  parameter int INDEX_WIDTH     = $clog2(COL_INDEX_SIZE),
  parameter int ROW_LEN_WIDTH   = $clog2(NUM_OF_COLS + 1),
  parameter int ROW_IDX_WIDTH   = $clog2(NUM_OF_ROWS + 1),
  parameter int NODE_INFO_WIDTH = INDEX_WIDTH + ROW_LEN_WIDTH + 1
) ();

  logic                                 start_i;
  logic [ROW_IDX_WIDTH-1:0]             num_rows_i;
  logic                                 busy_o;
  logic                                 done_o;
  logic                                 err_o;

  logic                                 info_rd_en_o;
  logic [ROW_IDX_WIDTH-1:0]             info_addr_o;
  logic [NODE_INFO_WIDTH-1:0]           info_rdata_i;

  logic                                 nz_rd_en_o;
  logic [INDEX_WIDTH-1:0]               nz_addr_o;
  logic [COL_IDX_WIDTH-1:0]             col_idx_rdata_i;
  logic [DATA_WIDTH-1:0]                value_rdata_i;

  logic                                 row_valid_o;
  logic                                 row_ready_i;
  logic [ROW_IDX_WIDTH-1:0]             row_id_o;
  logic [NUM_OF_COLS*COL_IDX_WIDTH-1:0] row_col_idx_o;
  logic [NUM_OF_COLS*DATA_WIDTH-1:0]    row_value_o;
  logic [ROW_LEN_WIDTH-1:0]             row_len_o;
  logic                                 row_flag_o;

  modport master (
    input  start_i, num_rows_i,
    output busy_o, done_o, err_o,
    output info_rd_en_o, info_addr_o,
    input  info_rdata_i,
    output nz_rd_en_o, nz_addr_o,
    input  col_idx_rdata_i, value_rdata_i,
    output row_valid_o,
    input  row_ready_i,
    output row_id_o, row_col_idx_o, row_value_o,
    output row_len_o, row_flag_o
  );

  modport slave (
    output start_i, num_rows_i,
    input  busy_o, done_o, err_o,
    input  info_rd_en_o, info_addr_o,
    output info_rdata_i,
    input  nz_rd_en_o, nz_addr_o,
    output col_idx_rdata_i, value_rdata_i,
    input  row_valid_o,
    output row_ready_i,
    input  row_id_o, row_col_idx_o, row_value_o,
    input  row_len_o, row_flag_o
  );

endinterface

// File: rtl/h_row_scheduler.sv
// h_row_scheduler: walks node_info row by row, gathers each row's
// nonzeros into a zero-padded buffer and emits it over valid/ready.
module h_row_scheduler #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_OF_COLS     = 5,
  parameter int NUM_OF_ROWS     = 5,
  parameter int COL_INDEX_SIZE  = 8,
  parameter int COL_IDX_WIDTH   = $clog2(NUM_OF_COLS),
  parameter int INDEX_WIDTH     = $clog2(COL_INDEX_SIZE),
  parameter int ROW_LEN_WIDTH   = $clog2(NUM_OF_COLS + 1),
  parameter int ROW_IDX_WIDTH   = $clog2(NUM_OF_ROWS + 1),
  parameter int NODE_INFO_WIDTH = INDEX_WIDTH + ROW_LEN_WIDTH + 1
) (
  input logic              clk,
  input logic              rst,
  h_row_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    INFO_RD,
    INFO_WAIT,
    NZ_RD,
    EMIT,
    DONE
  } state_t;

  localparam logic [ROW_LEN_WIDTH-1:0] MAX_LEN =
    ROW_LEN_WIDTH'(NUM_OF_COLS);

  state_t state;
  state_t state_nxt;

  logic [ROW_IDX_WIDTH-1:0] row_cnt;
  logic [ROW_IDX_WIDTH-1:0] num_rows;
  logic [INDEX_WIDTH-1:0]   idx;
  logic [ROW_LEN_WIDTH-1:0] len;
  logic [ROW_LEN_WIDTH-1:0] issue_cnt;
  logic [ROW_LEN_WIDTH-1:0] cap_cnt;
  logic                     flag;
  logic                     rd_pend;
  logic                     err;
  logic                     done_q;

  logic [COL_IDX_WIDTH-1:0] col_buf [NUM_OF_COLS];
  logic [DATA_WIDTH-1:0]    val_buf [NUM_OF_COLS];

  logic [INDEX_WIDTH-1:0]   info_idx;
  logic [ROW_LEN_WIDTH-1:0] info_len;
  logic                     info_flag;
  logic                     info_ovf;
  logic                     last_row;
  logic                     nz_fire;

  assign info_idx  = bus.info_rdata_i[NODE_INFO_WIDTH-1 -: INDEX_WIDTH];
  assign info_len  = bus.info_rdata_i[ROW_LEN_WIDTH:1];
  assign info_flag = bus.info_rdata_i[0];
  assign info_ovf  = info_len > MAX_LEN;
  assign last_row  = row_cnt == (num_rows - ROW_IDX_WIDTH'(1));
  assign nz_fire   = (state == NZ_RD) && (issue_cnt < len);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.num_rows_i != '0) begin
            state_nxt = INFO_RD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      INFO_RD: state_nxt = INFO_WAIT;
      INFO_WAIT: begin
        if (info_len == '0) begin
          state_nxt = EMIT;
        end else begin
          state_nxt = NZ_RD;
        end
      end
      NZ_RD: begin
        if (rd_pend && (cap_cnt == len - ROW_LEN_WIDTH'(1))) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bus.row_ready_i) begin
          state_nxt = last_row ? DONE : INFO_RD;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded strobes and addresses
  always_comb begin
    bus.busy_o       = state != IDLE;
    bus.info_rd_en_o = state == INFO_RD;
    bus.info_addr_o  = '0;
    if (state == INFO_RD) begin
      bus.info_addr_o = row_cnt;
    end
    bus.nz_rd_en_o  = nz_fire;
    bus.nz_addr_o   = '0;
    if (nz_fire) begin
      bus.nz_addr_o = idx + INDEX_WIDTH'(issue_cnt);
    end
    bus.row_valid_o = state == EMIT;
  end

  // row counter, row descriptor, gather buffers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt   <= '0;
      num_rows  <= '0;
      idx       <= '0;
      len       <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      flag      <= 1'b0;
      rd_pend   <= 1'b0;
      err       <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_OF_COLS; i++) begin
        col_buf[i] <= '0;
        val_buf[i] <= '0;
      end
    end else begin
      done_q <= state == DONE;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            num_rows <= bus.num_rows_i;
            row_cnt  <= '0;
            err      <= 1'b0;
          end
        end
        INFO_WAIT: begin
          idx       <= info_idx;
          flag      <= info_flag;
          len       <= info_ovf ? MAX_LEN : info_len;
          issue_cnt <= '0;
          cap_cnt   <= '0;
          rd_pend   <= 1'b0;
          if (info_ovf) begin
            err <= 1'b1;
          end
          for (int i = 0; i < NUM_OF_COLS; i++) begin
            col_buf[i] <= '0;
            val_buf[i] <= '0;
          end
        end
        NZ_RD: begin
          rd_pend <= nz_fire;
          if (nz_fire) begin
            issue_cnt <= issue_cnt + ROW_LEN_WIDTH'(1);
          end
          if (rd_pend) begin
            col_buf[cap_cnt] <= bus.col_idx_rdata_i;
            val_buf[cap_cnt] <= bus.value_rdata_i;
            cap_cnt          <= cap_cnt + ROW_LEN_WIDTH'(1);
          end
        end
        EMIT: begin
          if (bus.row_ready_i && !last_row) begin
            row_cnt <= row_cnt + ROW_IDX_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // row packet and status outputs straight from registers
  always_comb begin
    bus.row_col_idx_o = '0;
    bus.row_value_o   = '0;
    for (int i = 0; i < NUM_OF_COLS; i++) begin
      bus.row_col_idx_o[i*COL_IDX_WIDTH +: COL_IDX_WIDTH] = col_buf[i];
      bus.row_value_o[i*DATA_WIDTH +: DATA_WIDTH]         = val_buf[i];
    end
    bus.row_id_o   = row_cnt;
    bus.row_len_o  = len;
    bus.row_flag_o = flag;
    bus.err_o      = err;
    bus.done_o     = done_q;
  end

endmodule

// File: doc/h_row_scheduler.md
Name: h_row_scheduler

Overview:
- Sequencer that walks the CSR node_info table one row at a time.
- For each row it fetches that row's col_idx/value nonzeros from single-port, 1-cycle-latency memories and gathers them into a zero-padded row buffer.
- It hands each completed row to the downstream row consumer over a valid/ready handshake.
- Sits between the H storage memories and the row-parallel feature datapath, replacing the all-at-once H extraction.

Parameters:
- DATA_WIDTH, 8, value element width.
- NUM_OF_COLS, 5, row buffer slots (max nonzeros per row).
- NUM_OF_ROWS, 5, node_info table depth.
- COL_INDEX_SIZE, 8, nonzero memory depth.
- COL_IDX_WIDTH, $clog2(NUM_OF_COLS), column index width.
- INDEX_WIDTH, $clog2(COL_INDEX_SIZE), nonzero address width.
- ROW_LEN_WIDTH, $clog2(NUM_OF_COLS+1), row length width.
- ROW_IDX_WIDTH, $clog2(NUM_OF_ROWS+1), row counter width.
- NODE_INFO_WIDTH, INDEX_WIDTH+ROW_LEN_WIDTH+1, node_info word = {idx, row_len, flag}, with flag at bit 0.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, asynchronous, active-high reset.
- start_i, in, 1, start pulse; sampled only in IDLE.
- num_rows_i, in, ROW_IDX_WIDTH, rows to process; latched on accepted start.
- busy_o, out, 1, high in every state except IDLE.
- done_o, out, 1, 1-cycle completion pulse.
- err_o, out, 1, sticky row-length overflow flag; cleared on accepted start.
- info_rd_en_o, out, 1, node_info memory read strobe.
- info_addr_o, out, ROW_IDX_WIDTH, node_info read address.
- info_rdata_i, in, NODE_INFO_WIDTH, node_info read data; valid 1 cycle after strobe.
- nz_rd_en_o, out, 1, nonzero memory read strobe.
- nz_addr_o, out, INDEX_WIDTH, nonzero read address.
- col_idx_rdata_i, in, COL_IDX_WIDTH, column index data; valid 1 cycle after strobe.
- value_rdata_i, in, DATA_WIDTH, value data; valid 1 cycle after strobe.
- row_valid_o, out, 1, row packet valid.
- row_ready_i, in, 1, consumer ready.
- row_id_o, out, ROW_IDX_WIDTH, row number of the current packet.
- row_col_idx_o, out, NUM_OF_COLS*COL_IDX_WIDTH, flattened row buffer; slot 0 in the LSBs.
- row_value_o, out, NUM_OF_COLS*DATA_WIDTH, flattened row buffer; slot 0 in the LSBs.
- row_len_o, out, ROW_LEN_WIDTH, row length after clamping.
- row_flag_o, out, 1, flag bit from node_info.

Behaviour:
- Reset: rst asserted at any time forces IDLE and zeroes all counters, row buffers and outputs, including err_o and done_o, with no settling cycle. Reset mid-row aborts the row: no done_o, and no further memory reads.
- FSM states: IDLE, INFO_RD, INFO_WAIT, NZ_RD, EMIT, DONE.
- IDLE:
  - start_i with num_rows_i != 0: latch num_rows_i, clear row_cnt, clear err_o, go to INFO_RD.
  - start_i with num_rows_i == 0: go to DONE.
  - start_i in any other state is ignored.
- INFO_RD: info_rd_en_o = 1, info_addr_o = row_cnt; go to INFO_WAIT.
- INFO_WAIT:
  - Capture idx, len and flag from info_rdata_i.
  - Zero all row buffer slots.
  - If len > NUM_OF_COLS, set err_o and clamp len to NUM_OF_COLS.
  - len == 0: go to EMIT. Otherwise go to NZ_RD.
- NZ_RD: lasts len+1 cycles.
  - Issue counter k = 0..len-1: one read per cycle, nz_addr_o = idx + k, wrapping modulo 2^INDEX_WIDTH with no bounds check.
  - Capture counter: col_idx_rdata_i and value_rdata_i are written into slot k the cycle after read k is issued.
  - Go to EMIT when capture count == len.
- EMIT:
  - row_valid_o = 1; all row_* outputs held stable while row_valid_o && !row_ready_i. No memory reads in this state.
  - On row_valid_o && row_ready_i: if row_cnt == num_rows-1, go to DONE; else row_cnt++ and go to INFO_RD.
- DONE: done_o = 1 for one cycle; next state IDLE.
- Timing, taking the start_i sample as cycle 0:
  - INFO_RD at cycle 1.
  - row_valid_o first high at cycle 3 for len 0, or cycle 4+len for len >= 1.
  - Each subsequent row adds 1 cycle after its handshake before its INFO_RD.
- Slots >= len read as zero. Outputs are registered, with no combinational path from row_ready_i to any output except through FSM state.

Test Plan:
- Memory contents: node_info = {idx0,len2,f1}, {idx2,len0,f0}, {idx2,len3,f1}; col_idx = [1,3,0,2,4]; value = [10,20,30,40,50]; num_rows 3; ready tied high.
  - Row 0: row_valid at cycle 6, col {1,3,0,0,0}, val {10,20,0,0,0}, flag 1.
  - Row 1: all-zero buffers, len 0.
  - Row 2: col {0,2,4}, val {30,40,50}.
  - done_o pulses once after the row 2 handshake.
- Backpressure: hold row_ready_i low 5 cycles on row 0 -> row_* outputs stable, nz_rd_en_o/info_rd_en_o stay low, row 1 INFO_RD occurs 1 cycle after the handshake.
- Overflow: a node_info entry with len 7 (NUM_OF_COLS = 5) -> exactly 5 nz reads at idx..idx+4, row_len_o = 5, err_o set and held; err_o cleared by the next start.
- num_rows_i = 0 -> done_o at cycle 2, no memory strobes, busy_o high only in cycle 1.
- start_i pulsed while busy -> ignored, no change in sequence or num_rows.
- rst asserted during the NZ_RD of row 0 -> all outputs 0 immediately, FSM in IDLE, no done_o; a fresh start replays row 0 correctly.
